mul_add: RTL and testbench

- Sequential radix-2 shift-add multiply-accumulate. Computes p = q*y + r, one multiplier bit per clock.
- Inverse companion of the team's sequential integer divider: fed a divider's (q, y, r), it reconstructs the dividend x.
- Used for divider round-trip checking and as a small-area multiplier in the datapath library.
- Handshake matches the divider's: start / busy / valid.

---
 rtl/mul_add.sv | 85 ++++++++
 tb/tb_mul_add.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mul_add.sv
// Sequential radix-2 shift-add multiply-accumulate: p = q*y + r, one multiplier bit per clock.
// Start/busy/valid handshake; a start in any state restarts the operation.
module mul_add #(
  parameter int WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     q_i,
  input  logic [WIDTH-1:0]     y_i,
  input  logic [WIDTH-1:0]     r_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic                 ovf_o,
  output logic                 rerr_o,
  output logic [WIDTH-1:0]     x_o,
  output logic [2*WIDTH-1:0]   p_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;
  logic                 rerr_l_q;
  logic                 valid_q;
  logic                 ovf_q;
  logic                 rerr_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [2*WIDTH-1:0]   acc_d;

  // Max q*y+r is 2^W*(2^W-1), so the 2W-bit accumulator never wraps.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      rerr_l_q <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rerr_q   <= 1'b0;
      p_q      <= '0;
    end else if (start_i) begin
      state_q  <= S_RUN;
      acc_q    <= {{WIDTH{1'b0}}, r_i};
      mcand_q  <= {{WIDTH{1'b0}}, y_i};
      mplier_q <= q_i;
      cnt_q    <= CW'(WIDTH - 1);
      rerr_l_q <= (r_i >= y_i);
      valid_q  <= 1'b0;
    end else if (state_q == S_RUN) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
        acc_q <= acc_d;
      end else begin
        state_q <= S_IDLE;
        valid_q <= 1'b1;
        p_q     <= acc_d;
        ovf_q   <= |acc_d[2*WIDTH-1:WIDTH];
        rerr_q  <= rerr_l_q;
      end
    end
  end

  assign busy_o  = (state_q == S_RUN);
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
  assign rerr_o  = rerr_q;
  assign p_o     = p_q;
  assign x_o     = p_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_add.sv
// Bench for mul_add: arithmetic reference model checked every cycle, directed
// literal cases, randomized restarts, and divider round-trip over all x, y.
module tb_mul_add;

  localparam int W = 4;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           start_i = 1'b0;
  logic [W-1:0]   q_i = '0, y_i = '0, r_i = '0;
  logic           busy_o, valid_o, ovf_o, rerr_o;
  logic [W-1:0]   x_o;
  logic [2*W-1:0] p_o;

  int errors = 0;
  int checks = 0;

  mul_add #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .q_i(q_i), .y_i(y_i), .r_i(r_i),
    .busy_o(busy_o), .valid_o(valid_o), .ovf_o(ovf_o), .rerr_o(rerr_o),
    .x_o(x_o), .p_o(p_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result is plain q*y+r, published WIDTH edges after the last start.
  logic           m_busy = 1'b0, m_valid = 1'b0, m_ovf = 1'b0, m_rerr = 1'b0;
  logic [2*W-1:0] m_p = '0;
  int             m_left = 0;
  int             pend_p = 0;
  logic           pend_rerr = 1'b0;
  logic           chk_en = 1'b0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_busy = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; m_rerr = 1'b0;
      m_p = '0; m_left = 0;
    end else if (start_i) begin
      m_busy = 1'b1; m_valid = 1'b0; m_left = W;
      pend_p = int'(q_i) * int'(y_i) + int'(r_i);
      pend_rerr = (r_i >= y_i);
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_valid = 1'b1;
        m_p = (2*W)'(pend_p);
        m_ovf = (pend_p >= (1 << W));
        m_rerr = pend_rerr;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("model_busy", busy_o, m_busy);
      check("model_valid", valid_o, m_valid);
      check("model_p", p_o, m_p);
      check("model_x", x_o, m_p[W-1:0]);
      check("model_ovf", ovf_o, m_ovf);
      check("model_rerr", rerr_o, m_rerr);
    end
  end

  task automatic do_start(input int q, input int y, input int r, input int hold);
    @(negedge clk_i);
    start_i = 1'b1;
    q_i = W'(q); y_i = W'(y); r_i = W'(r);
    for (int k = 1; k < hold; k++) begin
      @(negedge clk_i);
      q_i = W'(q); y_i = W'(y); r_i = W'(r);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    q_i = W'($urandom); y_i = W'($urandom); r_i = W'($urandom);
  endtask

  // Counts negedges with busy high, starting just after the start edge; bounded.
  task automatic wait_done(output int bc);
    bc = 0;
    while (busy_o && bc < 20) begin
      bc++;
      @(negedge clk_i);
    end
    if (bc >= 20) begin
      errors++;
      $display("FAIL wait_done: timeout, busy still %0b", busy_o);
    end
  endtask

  initial begin
    int bc;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_p", p_o, 0);
    check("rst_x", x_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_rerr", rerr_o, 0);

    do_start(3, 4, 1, 1);
    wait_done(bc);
    check("lat_3_4_1", bc, W);
    check("valid_3_4_1", valid_o, 1);
    check("p_3_4_1", p_o, 13);
    check("x_3_4_1", x_o, 13);
    check("ovf_3_4_1", ovf_o, 0);
    check("rerr_3_4_1", rerr_o, 0);
    repeat (5) @(negedge clk_i);
    check("hold_valid", valid_o, 1);
    check("hold_p", p_o, 13);

    do_start(15, 15, 15, 1);
    wait_done(bc);
    check("p_max", p_o, 240);
    check("x_max", x_o, 0);
    check("ovf_max", ovf_o, 1);
    check("rerr_max", rerr_o, 1);

    do_start(0, 7, 3, 1);
    wait_done(bc);
    check("lat_q0", bc, W);
    check("p_q0", p_o, 3);
    check("ovf_q0", ovf_o, 0);
    check("rerr_q0", rerr_o, 0);

    do_start(9, 0, 5, 1);
    wait_done(bc);
    check("lat_y0", bc, W);
    check("p_y0", p_o, 5);
    check("x_y0", x_o, 5);
    check("rerr_y0", rerr_o, 1);
    check("ovf_y0", ovf_o, 0);

    do_start(2, 3, 0, 1);
    check("restart_valid0", valid_o, 0);
    do_start(5, 2, 1, 1);
    check("restart_valid1", valid_o, 0);
    wait_done(bc);
    check("lat_restart", bc, W);
    check("p_restart", p_o, 11);

    do_start(7, 7, 0, 1);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_p", p_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (8) @(negedge clk_i);
    check("arst_no_result", valid_o, 0);

    // Random starts with random gaps: exercises restart mid-run and held start.
    for (int n = 0; n < 150; n++) begin
      do_start($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               ($urandom_range(0, 7) == 0) ? $urandom_range(2, 4) : 1);
      repeat ($urandom_range(0, 6)) @(negedge clk_i);
    end
    repeat (W + 2) @(negedge clk_i);

    // Divider round-trip: (x/y, y, x%y) must rebuild x exactly.
    for (int xv = 0; xv < 16; xv++) begin
      for (int yv = 1; yv < 16; yv++) begin
        do_start(xv / yv, yv, xv % yv, 1);
        wait_done(bc);
        check("rt_x", x_o, xv);
        check("rt_ovf", ovf_o, 0);
        check("rt_rerr", rerr_o, 0);
      end
    end

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
